// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte FIFO sitting between a UART receiver and a CPU.
// Ports:
//   clk, reset        - single clock, asynchronous active-high reset
//   rx_done_tick      - push request from the receiver; rx_data is the byte
//   s_tick            - oversampling tick, drives the idle/timeout counter
//   rd_en             - CPU pop request (ignored while empty)
//   overrun_clr       - clears the sticky overrun flag
//   rd_data           - head entry, first-word-fall-through, 8'h00 when empty
//   empty/full/count  - fill status, combinational from registered state
//   overrun           - sticky: a byte was dropped because the FIFO was full
//   rx_irq            - count >= THRESH
//   timeout_irq       - registered; FIFO non-empty and idle for TO_TICKS s_ticks
module uart_rx_fifo #(
    parameter int DEPTH    = 16,
    parameter int THRESH   = 8,
    parameter int TO_TICKS = 512
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx_done_tick,
    input  logic [7:0]             rx_data,
    input  logic                   s_tick,
    input  logic                   rd_en,
    input  logic                   overrun_clr,
    output logic [7:0]             rd_data,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overrun,
    output logic                   rx_irq,
    output logic                   timeout_irq
);

    localparam int          AW     = $clog2(DEPTH);
    localparam int          CW     = AW + 1;
    localparam logic [15:0] TO_MAX = 16'(TO_TICKS);

    typedef enum logic [1:0] {S_EMPTY, S_PARTIAL, S_FULL} state_t;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    state_t        state_q, state_d;
    logic          overrun_q, overrun_d;
    logic [15:0]   idle_q, idle_d;
    logic          timeout_q, timeout_d;
    logic          push, pop;

    // Pop only when something is stored; a push into a full FIFO is allowed
    // when the same cycle frees an entry.
    assign pop  = rd_en && !empty;
    assign push = rx_done_tick && (!full || pop);

    always_comb begin
        wr_ptr_d  = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d  = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // count moves by at most one per cycle, so no state is ever skipped
        if (count_d == '0)
            state_d = S_EMPTY;
        else if (count_d == CW'(DEPTH))
            state_d = S_FULL;
        else
            state_d = S_PARTIAL;

        // A drop is a receive while full with nothing leaving; a drop wins
        // over a simultaneous clear.
        if (rx_done_tick && full && !pop)
            overrun_d = 1'b1;
        else if (overrun_clr)
            overrun_d = 1'b0;
        else
            overrun_d = overrun_q;

        if (push || pop || empty)
            idle_d = '0;
        else if (s_tick && idle_q != TO_MAX)
            idle_d = idle_q + 16'd1;
        else
            idle_d = idle_q;

        // Evaluated on next-state values so the irq drops on the same edge
        // that a push or pop resets the idle counter.
        timeout_d = (idle_d == TO_MAX) && (count_d != '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            state_q   <= S_EMPTY;
            overrun_q <= 1'b0;
            idle_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            state_q   <= state_d;
            overrun_q <= overrun_d;
            idle_q    <= idle_d;
            timeout_q <= timeout_d;
        end
    end

    // Storage is not reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_q] <= rx_data;
    end

    assign empty       = (state_q == S_EMPTY);
    assign full        = (state_q == S_FULL);
    assign count       = count_q;
    assign rx_irq      = (count_q >= CW'(THRESH));
    assign overrun     = overrun_q;
    assign timeout_irq = timeout_q;
    assign rd_data     = empty ? 8'h00 : mem[rd_ptr_q];

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_done_tick, s_tick, rd_en, overrun_clr;
    logic [7:0] rx_data;
    logic [7:0] rd_data;
    logic       empty, full, overrun, rx_irq, timeout_irq;
    logic [4:0] count;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_rx_fifo #(.DEPTH(16), .THRESH(8), .TO_TICKS(4)) dut (
        .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
        .s_tick(s_tick), .rd_en(rd_en), .overrun_clr(overrun_clr),
        .rd_data(rd_data), .empty(empty), .full(full), .count(count),
        .overrun(overrun), .rx_irq(rx_irq), .timeout_irq(timeout_irq)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted pop must present the oldest expected byte.
    always @(negedge clk) begin
        if (!reset && rd_en && !empty) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_data: popped %0h with nothing expected", rd_data);
            end else begin
                chk("pop_data", int'(rd_data), int'(exp_q.pop_front()));
            end
        end
    end

    // One clock: inputs held across the edge, released 1ns after it.
    // acc marks a push the bench expects the FIFO to accept.
    task automatic step(input logic p, input logic [7:0] d, input logic r,
                        input logic t, input logic c, input logic acc);
        rx_done_tick = p; rx_data = d; rd_en = r; s_tick = t; overrun_clr = c;
        if (acc) exp_q.push_back(d);
        @(posedge clk);
        #1;
        rx_done_tick = 1'b0; rd_en = 1'b0; s_tick = 1'b0; overrun_clr = 1'b0;
        rx_data = 8'h00;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        rx_done_tick = 1'b0; rx_data = 8'h00; s_tick = 1'b0; rd_en = 1'b0; overrun_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_rx_irq", int'(rx_irq), 0);
        chk("rst_timeout", int'(timeout_irq), 0);
        chk("rst_rd_data", int'(rd_data), 0);
        reset = 1'b0;

        // Two bytes in, two out; first push lands on the first edge after reset.
        step(1, 8'hA5, 0, 0, 0, 1); chk("cnt_a", int'(count), 1);
        chk("fwft_a5", int'(rd_data), 8'hA5);
        step(1, 8'h3C, 0, 0, 0, 1); chk("cnt_b", int'(count), 2);
        step(0, 8'h00, 1, 0, 0, 0); chk("cnt_c", int'(count), 1);
        step(0, 8'h00, 1, 0, 0, 0); chk("cnt_d", int'(count), 0);
        chk("empty_d", int'(empty), 1);
        step(0, 8'h00, 1, 0, 0, 0); chk("pop_empty_cnt", int'(count), 0);

        // Fill to 16; irq from the 8th entry.
        for (int i = 0; i < 16; i++) begin
            step(1, 8'(i), 0, 0, 0, 1);
            chk("fill_cnt", int'(count), i + 1);
            chk("fill_irq", int'(rx_irq), (i + 1 >= 8) ? 1 : 0);
        end
        chk("full", int'(full), 1);
        step(1, 8'hFF, 0, 0, 0, 0);
        chk("ovr_set", int'(overrun), 1);
        chk("ovr_cnt", int'(count), 16);
        step(0, 8'h00, 0, 0, 1, 0); chk("ovr_clr", int'(overrun), 0);
        step(1, 8'hEE, 0, 0, 1, 0); chk("ovr_drop_wins", int'(overrun), 1);
        step(0, 8'h00, 0, 0, 1, 0); chk("ovr_clr2", int'(overrun), 0);

        // Full push+pop: accepted, no overrun.
        step(1, 8'h77, 1, 0, 0, 1);
        chk("fullpp_cnt", int'(count), 16);
        chk("fullpp_ovr", int'(overrun), 0);
        chk("fullpp_full", int'(full), 1);
        for (int i = 0; i < 16; i++) step(0, 8'h00, 1, 0, 0, 0);
        chk("drain_empty", int'(empty), 1);
        chk("drain_rd", int'(rd_data), 0);

        // Empty push+pop: pop ignored, push accepted.
        step(1, 8'h5A, 1, 0, 0, 1);
        chk("emptypp_cnt", int'(count), 1);
        chk("emptypp_rd", int'(rd_data), 8'h5A);

        // Timeout with TO_TICKS=4.
        for (int i = 0; i < 3; i++) step(0, 8'h00, 0, 1, 0, 0);
        chk("to_early", int'(timeout_irq), 0);
        step(0, 8'h00, 0, 0, 0, 0); chk("to_no_tick", int'(timeout_irq), 0);
        step(0, 8'h00, 0, 1, 0, 0); chk("to_set", int'(timeout_irq), 1);
        step(0, 8'h00, 0, 1, 0, 0); chk("to_sat", int'(timeout_irq), 1);
        step(0, 8'h00, 1, 0, 0, 0); chk("to_pop_clr", int'(timeout_irq), 0);
        for (int i = 0; i < 5; i++) step(0, 8'h00, 0, 1, 0, 0);
        chk("to_empty", int'(timeout_irq), 0);

        // Build count=5 with overrun=1, then reset asynchronously mid-cycle.
        for (int i = 0; i < 16; i++) step(1, 8'h80 + 8'(i), 0, 0, 0, 1);
        step(1, 8'hFF, 0, 0, 0, 0);
        for (int i = 0; i < 11; i++) step(0, 8'h00, 1, 0, 0, 0);
        chk("pre_rst_cnt", int'(count), 5);
        chk("pre_rst_ovr", int'(overrun), 1);
        #2 reset = 1'b1;
        #1;
        chk("arst_cnt", int'(count), 0);
        chk("arst_empty", int'(empty), 1);
        chk("arst_ovr", int'(overrun), 0);
        chk("arst_to", int'(timeout_irq), 0);
        chk("arst_rd", int'(rd_data), 0);
        exp_q.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        step(1, 8'h11, 0, 0, 0, 1);
        chk("post_rst_cnt", int'(count), 1);
        chk("post_rst_rd", int'(rd_data), 8'h11);
        step(0, 8'h00, 1, 0, 0, 0);
        chk("post_rst_empty", int'(empty), 1);

        chk("sb_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
